// File: rtl/score_bcd_seq.sv
// score_bcd_seq: sequential binary-to-BCD converter (shift-and-add-3) with a
// random-access digit read port and leading-zero blanking for display paths.
// Ports:
//   i_clk, i_rst        clock, synchronous active-high reset
//   i_start, i_value    conversion request (IDLE only) and binary operand
//   o_busy, o_done      conversion in progress, single-cycle result pulse
//   o_bcd               registered packed BCD result, digit i at [4i+3:4i]
//   i_digit_sel         digit index for the read port
//   o_digit, o_blank    combinational selected digit and leading-zero flag
module score_bcd_seq #(
    parameter int unsigned WIDTH  = 20,
    parameter int unsigned DIGITS = 7
) (
    input  logic                  i_clk,
    input  logic                  i_rst,
    input  logic                  i_start,
    input  logic [WIDTH-1:0]      i_value,
    output logic                  o_busy,
    output logic                  o_done,
    output logic [4*DIGITS-1:0]   o_bcd,
    input  logic [2:0]            i_digit_sel,
    output logic [3:0]            o_digit,
    output logic                  o_blank
);

    localparam int unsigned BCD_W = 4 * DIGITS;
    localparam int unsigned CNT_W = $clog2(WIDTH);

    typedef enum logic [1:0] {
        S_IDLE,
        S_SHIFT,
        S_DONE
    } state_t;

    state_t             r_state;
    state_t             w_state_nxt;
    logic [WIDTH-1:0]   r_shift;
    logic [WIDTH-1:0]   w_shift_nxt;
    logic [BCD_W-1:0]   r_scratch;
    logic [BCD_W-1:0]   w_scratch_nxt;
    logic [CNT_W-1:0]   r_cnt;
    logic [CNT_W-1:0]   w_cnt_nxt;
    logic [BCD_W-1:0]   r_bcd;
    logic [BCD_W-1:0]   w_bcd_nxt;
    logic               r_busy;
    logic               r_done;
    logic [BCD_W-1:0]   w_adj;
    logic [BCD_W-1:0]   w_shifted;
    logic [31:0]        w_sel;
    logic               w_upper_zero;

    // Per-digit add-3 correction ahead of the shift; digits never carry.
    always_comb begin
        w_adj = '0;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            if (r_scratch[4*i +: 4] >= 4'd5) begin
                w_adj[4*i +: 4] = r_scratch[4*i +: 4] + 4'd3;
            end else begin
                w_adj[4*i +: 4] = r_scratch[4*i +: 4];
            end
        end
    end

    assign w_shifted = {w_adj[BCD_W-2:0], r_shift[WIDTH-1]};

    // Next-state and datapath update.
    always_comb begin
        w_state_nxt   = r_state;
        w_shift_nxt   = r_shift;
        w_scratch_nxt = r_scratch;
        w_cnt_nxt     = r_cnt;
        w_bcd_nxt     = r_bcd;
        case (r_state)
            S_IDLE: begin
                if (i_start) begin
                    w_state_nxt   = S_SHIFT;
                    w_shift_nxt   = i_value;
                    w_scratch_nxt = '0;
                    w_cnt_nxt     = '0;
                end
            end
            S_SHIFT: begin
                w_scratch_nxt = w_shifted;
                w_shift_nxt   = {r_shift[WIDTH-2:0], 1'b0};
                w_cnt_nxt     = r_cnt + CNT_W'(1);
                // Result is taken from the shift that completes this cycle.
                if (r_cnt == CNT_W'(WIDTH - 1)) begin
                    w_bcd_nxt   = w_shifted;
                    w_state_nxt = S_DONE;
                end
            end
            S_DONE: begin
                w_state_nxt = S_IDLE;
            end
            default: begin
                w_state_nxt = S_IDLE;
            end
        endcase
    end

    // State and datapath registers; busy/done registered from the next state.
    always_ff @(posedge i_clk) begin
        if (i_rst) begin
            r_state   <= S_IDLE;
            r_shift   <= '0;
            r_scratch <= '0;
            r_cnt     <= '0;
            r_bcd     <= '0;
            r_busy    <= 1'b0;
            r_done    <= 1'b0;
        end else begin
            r_state   <= w_state_nxt;
            r_shift   <= w_shift_nxt;
            r_scratch <= w_scratch_nxt;
            r_cnt     <= w_cnt_nxt;
            r_bcd     <= w_bcd_nxt;
            r_busy    <= (w_state_nxt != S_IDLE);
            r_done    <= (w_state_nxt == S_DONE);
        end
    end

    assign o_busy = r_busy;
    assign o_done = r_done;
    assign o_bcd  = r_bcd;
    assign w_sel  = 32'(i_digit_sel);

    // Read port: digit mux and "this digit and all above it are zero" flag.
    always_comb begin
        o_digit      = 4'd0;
        w_upper_zero = 1'b1;
        for (int unsigned i = 0; i < DIGITS; i++) begin
            if (i == w_sel) begin
                o_digit = r_bcd[4*i +: 4];
            end
            if ((i >= w_sel) && (r_bcd[4*i +: 4] != 4'd0)) begin
                w_upper_zero = 1'b0;
            end
        end
        if (w_sel >= DIGITS) begin
            o_blank = 1'b1;
        end else if (w_sel == 32'd0) begin
            o_blank = 1'b0;
        end else begin
            o_blank = w_upper_zero;
        end
    end

endmodule

// File: tb/tb_score_bcd_seq.sv
`timescale 1ns/1ps
module tb_score_bcd_seq;

    logic        clk = 1'b0;
    logic        i_rst;
    logic        i_start;
    logic [19:0] i_value;
    logic        o_busy;
    logic        o_done;
    logic [27:0] o_bcd;
    logic [2:0]  i_digit_sel;
    logic [3:0]  o_digit;
    logic        o_blank;

    int          vectors = 0;
    int          miscompares = 0;
    logic [27:0] last_exp;

    typedef struct {
        logic [19:0] v;
        logic [27:0] exp;
    } vec_t;
    vec_t tbl[10];

    always #10 clk = ~clk;

    score_bcd_seq dut (
        .i_clk       (clk),
        .i_rst       (i_rst),
        .i_start     (i_start),
        .i_value     (i_value),
        .o_busy      (o_busy),
        .o_done      (o_done),
        .o_bcd       (o_bcd),
        .i_digit_sel (i_digit_sel),
        .o_digit     (o_digit),
        .o_blank     (o_blank)
    );

    task automatic tick();
        @(posedge clk);
        #1;
    endtask

    task automatic chk(input string nm, input logic [63:0] act, input logic [63:0] exp);
        vectors++;
        if (act !== exp) begin
            miscompares++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    function automatic int unsigned pow10(input int unsigned n);
        int unsigned p = 1;
        for (int unsigned k = 0; k < n; k++) p = p * 10;
        return p;
    endfunction

    // Decimal digits by plain division, independent of any shifting scheme.
    function automatic logic [27:0] ref_bcd(input int unsigned v);
        logic [27:0]  r = '0;
        int unsigned  x = v;
        for (int k = 0; k < 7; k++) begin
            r[4*k +: 4] = 4'(x % 10);
            x = x / 10;
        end
        return r;
    endfunction

    function automatic logic [3:0] ref_digit(input int unsigned v, input int unsigned s);
        if (s >= 7) return 4'd0;
        return 4'((v / pow10(s)) % 10);
    endfunction

    function automatic logic ref_blank(input int unsigned v, input int unsigned s);
        if (s >= 7) return 1'b1;
        if (s == 0) return 1'b0;
        return (v < pow10(s)) ? 1'b1 : 1'b0;
    endfunction

    task automatic rp_check(input int unsigned v, input string nm);
        for (int s = 0; s < 8; s++) begin
            i_digit_sel = 3'(s);
            #1;
            chk($sformatf("%s digit sel%0d", nm, s), 64'(o_digit), 64'(ref_digit(v, s)));
            chk($sformatf("%s blank sel%0d", nm, s), 64'(o_blank), 64'(ref_blank(v, s)));
        end
        i_digit_sel = 3'd0;
    endtask

    // Start in the current cycle (cycle 0); done must land in cycle 21.
    task automatic conv(input logic [19:0] v, input logic [27:0] exp, input string nm);
        int   c;
        logic ok;
        i_value = v;
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
        c = 1;
        chk({nm, " busy@1"}, 64'(o_busy), 64'd1);
        while (!o_done && c < 40) begin
            i_value = 20'($urandom);
            tick();
            c++;
        end
        chk({nm, " done_cycle"}, 64'(c), 64'd21);
        chk({nm, " bcd"}, 64'(o_bcd), 64'(exp));
        ok = 1'b1;
        for (int k = 0; k < 7; k++) if (o_bcd[4*k +: 4] > 4'd9) ok = 1'b0;
        chk({nm, " digits<=9"}, 64'(ok), 64'd1);
        tick();
        chk({nm, " busy@22"}, 64'(o_busy), 64'd0);
        chk({nm, " done@22"}, 64'(o_done), 64'd0);
        last_exp = exp;
    endtask

    initial begin
        #10_000_000;
        $display("FAIL watchdog: simulation did not finish, got timeout expected completion");
        $fatal(1, "watchdog");
    end

    initial begin
        int          ndone;
        int unsigned rv;

        tbl[0] = '{20'd1048575, 28'h1048575};
        tbl[1] = '{20'd0,       28'h0000000};
        tbl[2] = '{20'd999999,  28'h0999999};
        tbl[3] = '{20'd907,     28'h0000907};
        tbl[4] = '{20'd1,       28'h0000001};
        tbl[5] = '{20'd9,       28'h0000009};
        tbl[6] = '{20'd10,      28'h0000010};
        tbl[7] = '{20'd99,      28'h0000099};
        tbl[8] = '{20'd100000,  28'h0100000};
        tbl[9] = '{20'd524288,  28'h0524288};

        i_rst = 1'b1;
        i_start = 1'b0;
        i_value = '0;
        i_digit_sel = 3'd0;
        repeat (2) tick();
        i_rst = 1'b0;
        chk("reset busy", 64'(o_busy), 64'd0);
        chk("reset done", 64'(o_done), 64'd0);
        chk("reset bcd", 64'(o_bcd), 64'd0);
        rp_check(0, "reset");
        last_exp = '0;

        // Reset wins over a simultaneous start.
        i_rst = 1'b1;
        i_start = 1'b1;
        i_value = 20'd77;
        tick();
        i_rst = 1'b0;
        i_start = 1'b0;
        tick();
        chk("rst_over_start busy", 64'(o_busy), 64'd0);

        // Table vectors, back-to-back.
        for (int n = 0; n < 10; n++) begin
            conv(tbl[n].v, tbl[n].exp, $sformatf("tbl%0d", n));
            rp_check(int'(tbl[n].v), $sformatf("tbl%0d rp", n));
        end

        // Start pulses in cycles 5 and 21 are ignored; bcd holds until done.
        i_value = 20'd12345;
        i_start = 1'b1;
        tick();
        for (int c = 1; c <= 21; c++) begin
            if (c == 5 || c == 21) begin
                i_start = 1'b1;
                i_value = 20'd54321;
            end else begin
                i_start = 1'b0;
                i_value = 20'($urandom);
            end
            if (c < 21) begin
                chk($sformatf("ign bcd_hold@%0d", c), 64'(o_bcd), 64'(last_exp));
                chk($sformatf("ign done@%0d", c), 64'(o_done), 64'd0);
                chk($sformatf("ign busy@%0d", c), 64'(o_busy), 64'd1);
            end else begin
                chk("ign done@21", 64'(o_done), 64'd1);
                chk("ign bcd@21", 64'(o_bcd), 64'h0012345);
            end
            tick();
        end
        i_start = 1'b0;
        last_exp = 28'h0012345;
        for (int c = 22; c <= 24; c++) begin
            chk($sformatf("ign idle busy@%0d", c), 64'(o_busy), 64'd0);
            chk($sformatf("ign idle bcd@%0d", c), 64'(o_bcd), 64'h0012345);
            tick();
        end

        // Reset in cycle 10 of a conversion discards it.
        i_value = 20'd999999;
        i_start = 1'b1;
        tick();
        i_start = 1'b0;
        repeat (9) tick();
        i_rst = 1'b1;
        tick();
        i_rst = 1'b0;
        chk("midrst busy", 64'(o_busy), 64'd0);
        chk("midrst done", 64'(o_done), 64'd0);
        chk("midrst bcd", 64'(o_bcd), 64'd0);
        ndone = 0;
        for (int c = 0; c < 30; c++) begin
            if (o_done) ndone++;
            tick();
        end
        chk("midrst no_done", 64'(ndone), 64'd0);
        chk("midrst bcd_after", 64'(o_bcd), 64'd0);
        conv(20'd42, 28'h0000042, "after_rst");

        // Random sweep against the decimal model.
        for (int n = 0; n < 150; n++) begin
            rv = $urandom_range(0, 1048575);
            conv(20'(rv), ref_bcd(rv), $sformatf("rand%0d v=%0d", n, rv));
            if (n % 25 == 0) rp_check(rv, $sformatf("rand%0d rp", n));
        end

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule

// File: doc/score_bcd_seq.md
# score_bcd_seq

Sequential binary-to-BCD conversion controller for the score/distance display path. It accepts a 20-bit binary value on a start strobe and runs a shift-and-add-3 (double-dabble) sequence over WIDTH cycles. It then publishes the result as a packed, registered DIGITS-digit BCD word. A random-access digit read port with leading-zero blanking lets the HUD renderer or 7-segment scanner fetch one digit per pixel or scan slot.

## Interface
Parameters:
- WIDTH, 20, binary input width
- DIGITS, 7, BCD digits produced; must satisfy 10^DIGITS > 2^WIDTH - 1

Ports:
- clk  in  1  system clock; all state changes on the rising edge
- rst  in  1  reset, synchronous, active-high
- start  in  1  conversion request; sampled only in IDLE
- value  in  WIDTH  binary operand; sampled on the accepting edge only
- busy  out  1  high while a conversion is in progress (SHIFT or DONE)
- done  out  1  single-cycle pulse; the new result is valid on bcd in the same cycle
- bcd  out  4*DIGITS  registered result; digit i (10^i) at [4i+3:4i]
- digit_sel  in  3  digit index for the read port
- digit  out  4  combinational: bcd digit digit_sel; 0 if digit_sel >= DIGITS
- blank  out  1  combinational leading-zero flag for digit_sel

## Operation
- FSM states: IDLE, SHIFT, DONE.
- IDLE -> SHIFT on start=1:
  - Load value into the shift register.
  - Clear the BCD scratch register.
  - Set cnt=0.
- SHIFT, each cycle:
  - For every scratch digit >= 5, add 3 to it (4-bit, no carry between digits).
  - Shift {scratch, shiftreg} left by 1.
  - Increment cnt.
  - When cnt == WIDTH-1, the last shift completes: copy the final scratch to bcd and go to DONE.
- DONE: done=1 for this cycle only. The next state is always IDLE.
- start is ignored in SHIFT and DONE; requests are not queued.
- value changes after acceptance have no effect.
- bcd holds the previous result for the whole conversion and changes only on the edge entering DONE.
- blank=1 when either condition holds:
  - digit_sel >= DIGITS, or
  - digit_sel > 0 and every digit at indices digit_sel through DIGITS-1 is 0.
- Digit 0 never blanks; a value of 0 displays "0".
- The scratch width is 4*DIGITS. The add-3 correction guarantees no digit exceeds 9. Results are exact for all inputs 0 to 2^WIDTH-1.
- cnt is ceil(log2(WIDTH)) bits wide.
- Reset in any state, including mid-SHIFT:
  - state=IDLE, busy=0, done=0, bcd=0, scratch=0, cnt=0.
  - The in-flight conversion is discarded.
- rst has priority over start in the same cycle.

## Timing
- Reset values: busy=0, done=0, bcd=0. The read port outputs follow from bcd=0: digit=0, and blank=0 for sel 0, 1 otherwise.
- With start=1 in IDLE during cycle 0:
  - busy=1 in cycles 1 through WIDTH+1, i.e. cycles 1-21 at default.
  - SHIFT occupies cycles 1-20.
  - DONE is cycle 21: done=1 and the new bcd is visible.
  - IDLE resumes in cycle 22; the earliest next accepted start is in cycle 22.
- Latency: start to done is WIDTH+1 cycles. Throughput is one conversion per WIDTH+2 cycles.
- digit and blank are purely combinational from bcd and digit_sel, with zero-cycle latency.

## Test plan
- Reset then idle:
  - busy=0, done=0, bcd=0x0000000.
  - digit_sel=0 gives digit=0, blank=0; digit_sel=3 gives blank=1; digit_sel=7 gives digit=0, blank=1.
- start with value=1048575 in cycle 0:
  - done=1 exactly in cycle 21, bcd=0x1048575, busy low in cycle 22.
  - Read port returns sel6=1, sel5=0, sel4=4, sel0=5, with blank=0 for all.
- value=0, then value=999999, then value=907 (back-to-back, each start issued in the first IDLE cycle):
  - Results in order: 0x0000000, 0x0999999, 0x0000907.
  - For 907, blank=1 on sel 3-6 and blank=0 on sel 0-2 (the inner zero at sel 1 is not blanked).
- During a conversion of 12345:
  - Pulse start with value=54321 in cycle 5 and again in cycle 21: both are ignored.
  - The result is 0x0012345, and bcd holds the old value until cycle 21.
  - value toggling during SHIFT does not alter the result.
- Assert rst in cycle 10 of a conversion:
  - The next cycle shows busy=0, done=0, bcd=0, and no done pulse ever appears.
  - A new start with value=42 afterwards yields 0x0000042 after 21 cycles.
- Exhaustive or random sweep of 0 to 2^20-1 against a reference model: every digit <= 9 and every result exact.
